cpu_datapath: RTL

Register-level datapath of the 8-bit CPU. It sits opposite `control_unit` and consumes every control word that unit emits. It holds the FSM state register, PC, IR, A, B, the ALU result register and ZF. It returns `state`, `instr` and `zf` to the control unit, closing the control loop. It also drives the external byte-wide memory port.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/cpu_datapath_if.sv | 10 +
 rtl/alu_8b.sv | 29 ++
 rtl/cpu_datapath.sv | 108 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit CPU: FSM state codes and ALU opcodes.
package cpu_pkg;

    typedef logic [2:0] state_t;
    typedef logic [2:0] alu_op_t;

    localparam state_t FETCH      = 3'b000;
    localparam state_t DECODE     = 3'b001;
    localparam state_t EXECUTE    = 3'b010;
    localparam state_t MEMORY     = 3'b011;
    localparam state_t WRITEBACK  = 3'b100;
    localparam state_t HALT_STATE = 3'b101;

    localparam alu_op_t ALU_ADD  = 3'b000;
    localparam alu_op_t ALU_SUB  = 3'b001;
    localparam alu_op_t ALU_AND  = 3'b010;
    localparam alu_op_t ALU_OR   = 3'b011;
    localparam alu_op_t ALU_XOR  = 3'b100;
    localparam alu_op_t ALU_NOT  = 3'b101;
    localparam alu_op_t ALU_SHL  = 3'b110;
    localparam alu_op_t ALU_PASS = 3'b111;

    // Sign-extend a 4-bit branch offset to a full byte.
    function automatic logic [7:0] sext4(input logic [3:0] v);
        return {{4{v[3]}}, v};
    endfunction

endpackage

// File: rtl/cpu_datapath_if.sv
// Byte-wide external memory port of the CPU datapath.
interface cpu_datapath_if;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_wr;
    logic [7:0] mem_rdata;

    modport master (output mem_addr, output mem_wdata, output mem_wr, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_wr, output mem_rdata);
endinterface

// File: rtl/alu_8b.sv
// Combinational 8-bit ALU; carry/borrow are dropped.
module alu_8b
    import cpu_pkg::*;
(
    input  logic [7:0] op_a_i,
    input  logic [7:0] op_b_i,
    input  alu_op_t    opcode_i,
    output logic [7:0] result_o,
    output logic       zero_o
);

    // Operation decode; every opcode is defined so no default is needed.
    always_comb begin
        result_o = 8'h00;
        unique case (opcode_i)
            ALU_ADD:  result_o = op_a_i + op_b_i;
            ALU_SUB:  result_o = op_a_i - op_b_i;
            ALU_AND:  result_o = op_a_i & op_b_i;
            ALU_OR:   result_o = op_a_i | op_b_i;
            ALU_XOR:  result_o = op_a_i ^ op_b_i;
            ALU_NOT:  result_o = ~op_a_i;
            ALU_SHL:  result_o = {op_a_i[6:0], 1'b0};
            ALU_PASS: result_o = op_b_i;
            default:  result_o = 8'h00;
        endcase
        zero_o = (result_o == 8'h00);
    end

endmodule

// File: rtl/cpu_datapath.sv
// Register-level datapath of the 8-bit CPU: state, PC, IR, A, B, ALU result and ZF.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  state_t         next_state,
    input  logic           pc_we,
    input  logic           pc_sel,
    input  logic [3:0]     pc_offset,
    input  logic           addr_sel,
    input  logic [3:0]     addr_offset,
    input  logic           mem_sel,
    input  logic           mem_we,
    input  alu_op_t        alu_opcode,
    input  logic           alu_sel_a,
    input  logic           alu_sel_b,
    input  logic           alu_we,
    input  logic           zf_we,
    input  logic           ir_we,
    input  logic           a_sel,
    input  logic           a_we,
    input  logic           b_sel,
    input  logic           b_we,
    input  logic           halt,
    cpu_datapath_if.master mem_bus,
    output state_t         state,
    output logic [7:0]     instr,
    output logic           zf,
    output logic [7:0]     pc,
    output logic           halted
);

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
    logic       zf_q, zf_d;
    logic [7:0] op_a, op_b, alu_res;
    logic       alu_zero, run;

    alu_8b u_alu (
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .opcode_i (alu_opcode),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    // Operand muxes and halt gating; run=0 freezes every register and the write strobe.
    always_comb begin
        run  = (state_q != HALT_STATE);
        op_a = alu_sel_a ? pc_q : a_q;
        op_b = alu_sel_b ? {4'b0000, ir_q[3:0]} : b_q;
    end

    // Next-state for all registers; every source uses pre-edge register values.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        zf_d    = zf_q;
        if (run) begin
            state_d = halt ? HALT_STATE : next_state;
            if (pc_we)  pc_d  = pc_sel ? pc_q + sext4(pc_offset) : pc_q + 8'd1;
            if (ir_we)  ir_d  = mem_bus.mem_rdata;
            if (a_we)   a_d   = a_sel ? mem_bus.mem_rdata : alu_q;
            if (b_we)   b_d   = b_sel ? mem_bus.mem_rdata : alu_q;
            if (alu_we) alu_d = alu_res;
            if (zf_we)  zf_d  = alu_zero;
        end
    end

    // Register bank with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            alu_q   <= 8'h00;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            zf_q    <= zf_d;
        end
    end

    // Memory port and status outputs, combinational from current registers.
    always_comb begin
        mem_bus.mem_addr  = addr_sel ? b_q + {4'b0000, addr_offset} : pc_q;
        mem_bus.mem_wdata = mem_sel ? alu_q : a_q;
        mem_bus.mem_wr    = mem_we && run;
        state             = state_q;
        instr             = ir_q;
        zf                = zf_q;
        pc                = pc_q;
        halted            = !run;
    end

endmodule
